// File: rtl/nco_pkg.sv
// Shared definitions for the multi-waveform NCO.
// Holds the mode encodings, the quadrant ids and the mid-scale helper.
package nco_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } nco_mode_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  function automatic int midScale(input int dataW);
    return 1 << (dataW - 1);
  endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// Quarter-wave sine magnitude ROM with a registered read port.
// The table is built at elaboration from an integer Taylor series, so no vendor IP is needed.
module nco_sine_rom #(
  parameter int PHASE_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PHASE_W-3:0] i_addr,
  output logic [DATA_W-1:0]  o_mag
);

  localparam int     DEPTH  = 1 << (PHASE_W - 2);
  localparam longint SCALE  = 64'sd1 << 30;
  localparam longint PI_FIX = 64'sd3373259426;

  // Fixed-point sin(pi/2 * k / DEPTH), scaled to full scale and rounded to nearest.
  function automatic int sineMag(input int k);
    longint x;
    longint term;
    longint sum;
    longint fullScale;
    x    = (PI_FIX * longint'(k)) / longint'(2 * DEPTH);
    term = x;
    sum  = x;
    for (int i = 1; i <= 8; i++) begin
      term = (term * x) / SCALE;
      term = (term * x) / SCALE;
      term = -term / longint'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    fullScale = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    return int'((fullScale * sum + SCALE / 2) / SCALE);
  endfunction

  logic [DATA_W-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int MAG = sineMag(k);
    assign w_rom[k] = MAG[DATA_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_mag <= '0;
    else       o_mag <= w_rom[i_addr];
  end

endmodule

// File: rtl/nco_multiwave.sv
// Multi-waveform NCO: phase accumulator with FCW handshake, phase offset and clear,
// followed by a 3-stage lookup pipeline producing sine, square, triangle or sawtooth.
module nco_multiwave
  import nco_pkg::*;
#(
  parameter int               ACC_W   = 32,
  parameter int               PHASE_W = 10,
  parameter int               DATA_W  = 8,
  parameter logic [ACC_W-1:0] FCW_RST = ACC_W'(655)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [ACC_W-1:0]   fcw_in,
  input  logic               fcw_valid,
  output logic               fcw_ready,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic [1:0]         mode,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_valid
);

  localparam logic [DATA_W-1:0] MID   = DATA_W'(midScale(DATA_W));
  localparam int                EXT_W = (PHASE_W > DATA_W) ? PHASE_W : DATA_W + 1;

  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_fcw;
  logic               r_fcw_ready;
  logic [PHASE_W-1:0] r_p;
  nco_mode_e          r_mode1;
  nco_mode_e          r_mode2;
  logic [1:0]         r_q2;
  logic [DATA_W-1:0]  r_alt2;
  logic [DATA_W-1:0]  r_dout;
  logic [2:0]         r_vld;

  logic               w_accept;
  logic [1:0]         w_q;
  logic [PHASE_W-3:0] w_addr;
  logic [EXT_W-1:0]   w_pext;
  logic [DATA_W:0]    w_tri_raw;
  logic [DATA_W-1:0]  w_tri;
  logic [DATA_W-1:0]  w_saw;
  logic [DATA_W-1:0]  w_sq;
  logic [DATA_W-1:0]  w_alt;
  logic [DATA_W-1:0]  w_m;

  assign w_accept = fcw_valid & r_fcw_ready;

  // A new FCW takes effect one cycle after accept, so the phase stays continuous.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_acc       <= '0;
      r_fcw       <= FCW_RST;
      r_fcw_ready <= 1'b1;
    end else begin
      if (phase_clr)  r_acc <= '0;
      else if (en)    r_acc <= r_acc + r_fcw;
      if (w_accept)   r_fcw <= fcw_in;
      r_fcw_ready <= ~w_accept;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_p     <= '0;
      r_mode1 <= MODE_SINE;
    end else begin
      r_p     <= r_acc[ACC_W-1 -: PHASE_W] + phase_ofs;
      r_mode1 <= nco_mode_e'(mode);
    end
  end

  assign w_q    = r_p[PHASE_W-1 -: 2];
  assign w_addr = (w_q == QUAD_1 || w_q == QUAD_3) ? ~r_p[PHASE_W-3:0] : r_p[PHASE_W-3:0];

  // Phase left-aligned in a field wide enough for the triangle fold; short phases get zero LSBs.
  assign w_pext    = EXT_W'(r_p) << (EXT_W - PHASE_W);
  assign w_tri_raw = (DATA_W + 1)'(w_pext >> (EXT_W - DATA_W - 1));
  assign w_tri     = w_tri_raw[DATA_W] ? ~w_tri_raw[DATA_W-1:0] : w_tri_raw[DATA_W-1:0];
  assign w_saw     = DATA_W'(w_pext >> (EXT_W - DATA_W));
  assign w_sq      = {DATA_W{~r_p[PHASE_W-1]}};

  always_comb begin
    w_alt = w_saw;
    case (r_mode1)
      MODE_SQUARE: w_alt = w_sq;
      MODE_TRI:    w_alt = w_tri;
      default:     w_alt = w_saw;
    endcase
  end

  nco_sine_rom #(
    .PHASE_W (PHASE_W),
    .DATA_W  (DATA_W)
  ) u_rom (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_addr (w_addr),
    .o_mag  (w_m)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_q2    <= QUAD_0;
      r_mode2 <= MODE_SINE;
      r_alt2  <= '0;
    end else begin
      r_q2    <= w_q;
      r_mode2 <= r_mode1;
      r_alt2  <= w_alt;
    end
  end

  // Upper half of the sine wave in quadrants 0/1, lower half in 2/3.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_dout <= MID;
      r_vld  <= '0;
    end else begin
      if (r_mode2 == MODE_SINE) begin
        if (r_q2 == QUAD_0 || r_q2 == QUAD_1) r_dout <= MID + w_m;
        else                                  r_dout <= MID - w_m;
      end else begin
        r_dout <= r_alt2;
      end
      r_vld <= {r_vld[1:0], en};
    end
  end

  assign fcw_ready  = r_fcw_ready;
  assign dout       = r_dout;
  assign dout_valid = r_vld[2];

endmodule

// File: tb/tb_nco_multiwave.sv
// Self-checking bench for nco_multiwave: a reference model pushes expected samples
// into a queue each clock and they are compared when they reach the output.
module tb_nco_multiwave;

  localparam logic [31:0] FCW_START = 32'h4000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        phase_clr;
  logic [31:0] fcw_in;
  logic        fcw_valid;
  logic        fcw_ready;
  logic [9:0]  phase_ofs;
  logic [1:0]  mode;
  logic [7:0]  dout;
  logic        dout_valid;

  typedef struct {
    logic [7:0] data;
    logic       vld;
  } sample_t;

  sample_t     expQ[$];
  logic [31:0] mAcc;
  logic [31:0] mFcw;
  logic        mReady;
  int          checkCount = 0;
  int          passCount  = 0;

  logic [7:0]  seqDout [7] = '{8'd128, 8'd128, 8'd128, 8'd255, 8'd128, 8'd1, 8'd128};
  logic        seqVld  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  nco_multiwave #(
    .ACC_W   (32),
    .PHASE_W (10),
    .DATA_W  (8),
    .FCW_RST (FCW_START)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .phase_clr  (phase_clr),
    .fcw_in     (fcw_in),
    .fcw_valid  (fcw_valid),
    .fcw_ready  (fcw_ready),
    .phase_ofs  (phase_ofs),
    .mode       (mode),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  function automatic logic [7:0] waveModel(input logic [9:0] p, input logic [1:0] m);
    int         idx;
    int         mag;
    logic [8:0] t;
    case (m)
      2'd0: begin
        idx = int'(p[7:0]);
        if (p[8]) idx = 255 - idx;
        mag = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * real'(idx) / 256.0) + 0.5);
        return p[9] ? 8'(128 - mag) : 8'(128 + mag);
      end
      2'd1: return p[9] ? 8'd0 : 8'd255;
      2'd2: begin
        t = p[9:1];
        return t[8] ? ~t[7:0] : t[7:0];
      end
      default: return p[9:2];
    endcase
  endfunction

  task automatic resetModel();
    sample_t s;
    mAcc   = '0;
    mFcw   = FCW_START;
    mReady = 1'b1;
    expQ.delete();
    s.data = 8'd128;
    s.vld  = 1'b0;
    expQ.push_back(s);
    expQ.push_back(s);
  endtask

  task automatic stepCycle();
    logic [9:0] p;
    logic       accepted;
    sample_t    s;
    @(posedge sys_clk);
    p      = mAcc[31:22] + phase_ofs;
    s.data = waveModel(p, mode);
    s.vld  = en;
    expQ.push_back(s);
    accepted = fcw_valid && mReady;
    if (phase_clr)   mAcc = '0;
    else if (en)     mAcc = mAcc + mFcw;
    if (accepted)    mFcw = fcw_in;
    mReady = !accepted;
    #1;
    checkOutput("fcw_ready", {31'd0, fcw_ready}, {31'd0, mReady});
    if (expQ.size() == 3) begin
      s = expQ.pop_front();
      checkOutput("dout_valid", {31'd0, dout_valid}, {31'd0, s.vld});
      checkOutput("dout", {24'd0, dout}, {24'd0, s.data});
    end
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic [1:0] m,
                               input logic [9:0] ofs, input logic v, input logic [31:0] f,
                               input int cycles);
    en        = e;
    phase_clr = c;
    mode      = m;
    phase_ofs = ofs;
    fcw_valid = v;
    fcw_in    = f;
    for (int i = 0; i < cycles; i++) stepCycle();
  endtask

  initial begin
    sys_rst   = 1'b1;
    en        = 1'b1;
    phase_clr = 1'b0;
    mode      = 2'd0;
    phase_ofs = '0;
    fcw_valid = 1'b0;
    fcw_in    = '0;
    #1;
    checkOutput("rst_dout", {24'd0, dout}, 32'd128);
    checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, fcw_ready}, 32'd1);
    #2;
    sys_rst = 1'b0;
    resetModel();

    $display("[TB] sine with FCW = 2^30 after reset");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 32'd0, 1);
      checkOutput("seq_dout", {24'd0, dout}, {24'd0, seqDout[i]});
      checkOutput("seq_valid", {31'd0, dout_valid}, {31'd0, seqVld[i]});
    end

    $display("[TB] sawtooth then square with FCW = 2^26");
    applyStimulus(1'b1, 1'b0, 2'd3, 10'd0, 1'b1, 32'h0400_0000, 1);
    applyStimulus(1'b1, 1'b1, 2'd3, 10'd0, 1'b0, 32'd0, 1);
    applyStimulus(1'b1, 1'b0, 2'd3, 10'd0, 1'b0, 32'd0, 70);
    applyStimulus(1'b1, 1'b0, 2'd1, 10'd0, 1'b0, 32'd0, 80);
    applyStimulus(1'b1, 1'b0, 2'd2, 10'd0, 1'b0, 32'd0, 70);

    $display("[TB] FCW handshake with back-to-back valid");
    checkOutput("hs_ready0", {31'd0, fcw_ready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b1, 32'h8000_0000, 1);
    checkOutput("hs_ready1", {31'd0, fcw_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b1, 32'h2000_0000, 1);
    checkOutput("hs_ready2", {31'd0, fcw_ready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 32'd0, 10);

    $display("[TB] sine with 90 degree phase offset");
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b1, FCW_START, 1);
    applyStimulus(1'b1, 1'b1, 2'd0, 10'd256, 1'b0, 32'd0, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd256, 1'b0, 32'd0, 12);

    $display("[TB] random enable, mode and offset");
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b1, 32'h0123_4567, 1);
    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                    10'($urandom_range(0, 1023)), 1'b0, 32'd0, 1);

    $display("[TB] clear together with enable");
    applyStimulus(1'b1, 1'b1, 2'd0, 10'd0, 1'b0, 32'd0, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 32'd0, 3);
    checkOutput("clr_dout", {24'd0, dout}, 32'd128);
    applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 32'd0, 5);

    $display("[TB] reset in the middle of the stream");
    applyStimulus(1'b1, 1'b0, 2'd2, 10'd0, 1'b0, 32'd0, 4);
    fcw_valid = 1'b1;
    fcw_in    = 32'd5;
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("mid_rst_dout", {24'd0, dout}, 32'd128);
    checkOutput("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, fcw_ready}, 32'd1);
    en        = 1'b1;
    mode      = 2'd0;
    fcw_valid = 1'b0;
    #2;
    sys_rst = 1'b0;
    resetModel();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 32'd0, 1);
      checkOutput("rel_dout", {24'd0, dout}, {24'd0, seqDout[i]});
      checkOutput("rel_valid", {31'd0, dout_valid}, {31'd0, seqVld[i]});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nco_multiwave.md
Name: nco_multiwave

Overview:
- Parametrised numerically controlled oscillator that supersedes the fixed-FCW sine NCO feeding the 8-bit DAC.
- Adds run-time FCW loading through a valid/ready handshake, a phase-offset input and a synchronous phase clear.
- Adds four waveform modes (sine, square, triangle, sawtooth) and parametrised accumulator, phase and output widths.
- Sits between the PLL clock domain and the DA output register; one clock domain.

Parameters:
ACC_W, 32, phase accumulator width (bits).
PHASE_W, 10, truncated phase width used for waveform lookup (PHASE_W <= ACC_W, PHASE_W >= 4).
DATA_W, 8, output sample width, unsigned offset-binary.
FCW_RST, 655, FCW loaded at reset (fout = FCW * fclk / 2^ACC_W).

Ports:
sys_clk  in  1  sole clock.
sys_rst  in  1  asynchronous active-high reset.
en  in  1  accumulator advance enable.
phase_clr  in  1  synchronous accumulator clear.
fcw_in  in  ACC_W  new frequency control word.
fcw_valid  in  1  fcw_in qualifier.
fcw_ready  out  1  block can accept fcw_in.
phase_ofs  in  PHASE_W  phase offset added after truncation, sampled every cycle.
mode  in  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
dout  out  DATA_W  sample.
dout_valid  out  1  dout qualifier.

Behaviour:
- Reset values: accumulator = 0; fcw_reg = FCW_RST; fcw_ready = 1; dout = 2^(DATA_W-1); dout_valid = 0; all pipeline registers = 0.
- Stage 0 (accumulator):
  - phase_clr = 1: accumulator <= 0. Clear wins over en.
  - en = 1 (and no clear): accumulator <= accumulator + fcw_reg, modulo 2^ACC_W; wrap is silent.
  - en = 0: accumulator holds.
- FCW handshake:
  - Transfer occurs when fcw_valid & fcw_ready.
  - fcw_reg updates at the end of the accept cycle. The first accumulator add using the new value is on the next cycle, so phase stays continuous (no accumulator reset).
  - fcw_ready drops for exactly one cycle after an accept, then returns to 1.
  - fcw_valid while fcw_ready = 0 is ignored. The source holds fcw_in/fcw_valid until it sees ready.
- Stage 1: p <= acc[ACC_W-1 -: PHASE_W] + phase_ofs, modulo 2^PHASE_W. mode is registered alongside p.
- Stage 2: q = p[PHASE_W-1:PHASE_W-2] (quadrant); addr = p[PHASE_W-3:0], mirrored (bitwise inverted) when q is 1 or 3. Square, triangle and sawtooth values are computed here from p.
- Stage 3 (output register):
  - sine: ROM quarter-wave magnitude m, full-scale 2^(DATA_W-1)-1. Output is mid + m for q = 0/1 and mid - m for q = 2/3, where mid = 2^(DATA_W-1).
  - Quarter-wave ROM holds round((2^(DATA_W-1)-1) * sin(pi/2 * k / 2^(PHASE_W-2))) for k = 0..2^(PHASE_W-2)-1. Mirror addressing gives the peak at k_max; the sine output is therefore never 0.
  - square: all-ones when p MSB = 0, else 0.
  - triangle: take the top DATA_W+1 bits of p; fold (invert the lower DATA_W bits when the MSB is set); output the lower DATA_W bits.
  - sawtooth: p[PHASE_W-1 -: DATA_W], zero-padded on the right if PHASE_W < DATA_W.
- Latency: an accumulator value appears on dout 3 clocks after it is registered. A mode change affects dout 2 clocks after it is sampled with stage 1.
- dout_valid: a 3-deep shift register of en (stage 0 → 3), so a sample is valid only if the accumulator advanced. It is cleared only by sys_rst, not by phase_clr.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values, and any pending FCW transfer is discarded. On deassertion, the first valid sample appears 3 clocks after en is high.

Decomposition:
- Package nco_pkg:
  - mode encodings MODE_SINE / MODE_SQUARE / MODE_TRI / MODE_SAW;
  - localparam function for mid-scale;
  - quadrant constants.
- Sub-module nco_sine_rom (quarter-wave synchronous ROM, params PHASE_W/DATA_W, 1-cycle read). It is initialised by generate/function so there is no vendor IP dependency. Everything else stays in nco_multiwave.

Test Plan:
- Reset, FCW_RST=2^30, en=1, mode=0, phase_ofs=0 → dout_valid rises on the 3rd clock. The dout sequence is 128, 255, 128, 1 (repeating); before that, dout = 128.
- Same setup, mode=3 with FCW=2^26 → dout ramps 0, 4, 8, …, 252, then wraps to 0. Switch to mode=1 → 255 ×32 samples, then 0 ×32.
- FCW handshake: hold fcw_valid with fcw_in=2^31 on back-to-back cycles → fcw_ready pattern 1, 0, 1. Exactly the first request is accepted. The accumulator increments by 2^31 starting the cycle after the accept, with no phase jump.
- phase_ofs=256 (90°) with FCW=2^30 sine → output is the sequence shifted by one sample: 255, 128, 1, 128.
- phase_clr and en both high for one cycle at an arbitrary phase → accumulator = 0 next cycle; 3 clocks later dout = 128 (sine).
- Assert sys_rst mid-stream between clock edges → dout = 128, dout_valid = 0, fcw_ready = 1 immediately. After release, fcw_reg = FCW_RST.
